// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg
// Shared constants for the multi-channel PWM capture block:
//   - default NCH / CNT_W / SYNC_STAGES values
//   - per-channel FSM state encoding
//   - sel_width(): rd_sel width for a given channel count (never below 1)
package pwm_capture_pkg;

    localparam int DEF_NCH         = 4;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_RISE = 2'd1;
    localparam logic [1:0] ST_MEAS_HIGH = 2'd2;
    localparam logic [1:0] ST_MEAS_LOW  = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        WAIT_RISE = ST_WAIT_RISE,
        MEAS_HIGH = ST_MEAS_HIGH,
        MEAS_LOW  = ST_MEAS_LOW
    } state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_capture_multi_if.sv
// pwm_capture_multi_if
// Bundles the capture block's per-channel controls, PWM inputs and result
// readout. "intr" carries the capture-complete flag (int is a keyword).
//   master : host / stimulus side (drives pwm_in, controls, read select)
//   slave  : pwm_capture_multi side (drives flags and data)
interface pwm_capture_multi_if
    import pwm_capture_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W
);
    localparam int SEL_W = sel_width(NCH);

    logic [NCH-1:0]     pwm_in;
    logic [NCH-1:0]     trigger;
    logic [NCH-1:0]     stop;
    logic               cont;
    logic [NCH-1:0]     int_clr;
    logic [SEL_W-1:0]   rd_sel;
    logic               oe;
    logic [NCH-1:0]     intr;
    logic [NCH-1:0]     ovf;
    logic [NCH-1:0]     ovr;
    logic [NCH-1:0]     busy;
    logic [2*CNT_W-1:0] data;

    modport master (
        output pwm_in, trigger, stop, cont, int_clr, rd_sel, oe,
        input  intr, ovf, ovr, busy, data
    );

    modport slave (
        input  pwm_in, trigger, stop, cont, int_clr, rd_sel, oe,
        output intr, ovf, ovr, busy, data
    );

endinterface

// File: rtl/pwm_capture_chan.sv
// pwm_capture_chan
// One capture channel: synchroniser, edge detect, FSM, counter, result
// registers and sticky flags.
//   clk, rst        : clock, async active-low reset
//   pwm_in          : asynchronous PWM input
//   trigger, stop   : arm (ignored while busy) / abort (wins over trigger)
//   cont            : mode sampled when armed (1 = continuous)
//   int_clr         : clears intr/ovf/ovr (a same-cycle set wins)
//   high, period    : last completed measurement, always updated as a pair
//   intr, ovf, ovr  : complete / saturated / completion-while-intr flags
//   busy            : channel not IDLE
module pwm_capture_chan
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             trigger,
    input  logic             stop,
    input  logic             cont,
    input  logic             int_clr,
    output logic [CNT_W-1:0] high,
    output logic [CNT_W-1:0] period,
    output logic             intr,
    output logic             ovf,
    output logic             ovr,
    output logic             busy
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    state_e                 st_q, st_d;
    logic                   mode_q, mode_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       high_tmp_q, high_tmp_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   intr_q, intr_d;
    logic                   ovf_q, ovf_d;
    logic                   ovr_q, ovr_d;
    logic                   busy_q, busy_d;

    logic s, rise, fall, sat;
    logic [CNT_W-1:0] cnt_inc;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~prev_q;
    assign fall    = ~s & prev_q;
    assign sat     = (cnt_q == {CNT_W{1'b1}});
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], pwm_in};
        prev_d     = s;
        st_d       = st_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        high_tmp_d = high_tmp_q;
        high_d     = high_q;
        period_d   = period_q;
        // Clear first; any set below overrides it in the same cycle.
        intr_d     = intr_q & ~int_clr;
        ovf_d      = ovf_q  & ~int_clr;
        ovr_d      = ovr_q  & ~int_clr;

        case (st_q)
            IDLE: begin
                if (trigger && !stop) begin
                    st_d   = WAIT_RISE;
                    mode_d = cont;
                end
            end
            WAIT_RISE: begin
                if (stop) begin
                    st_d = IDLE;
                end else if (rise) begin
                    st_d  = MEAS_HIGH;
                    cnt_d = CNT_W'(1);
                end
            end
            MEAS_HIGH: begin
                if (stop) begin
                    st_d = IDLE;
                end else if (sat) begin
                    // No wrap: abandon the measurement, keep old results.
                    ovf_d  = 1'b1;
                    intr_d = 1'b1;
                    st_d   = IDLE;
                end else if (fall) begin
                    high_tmp_d = cnt_q;
                    cnt_d      = cnt_inc;
                    st_d       = MEAS_LOW;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            MEAS_LOW: begin
                if (stop) begin
                    st_d = IDLE;
                end else if (sat) begin
                    ovf_d  = 1'b1;
                    intr_d = 1'b1;
                    st_d   = IDLE;
                end else if (rise) begin
                    period_d = cnt_q;
                    high_d   = high_tmp_q;
                    intr_d   = 1'b1;
                    if (intr_q) ovr_d = 1'b1;
                    if (mode_q) begin
                        // This rise is also the start of the next period.
                        st_d  = MEAS_HIGH;
                        cnt_d = CNT_W'(1);
                    end else begin
                        st_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: st_d = IDLE;
        endcase

        busy_d = (st_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            st_q       <= IDLE;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            high_tmp_q <= '0;
            high_q     <= '0;
            period_q   <= '0;
            intr_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            st_q       <= st_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            high_tmp_q <= high_tmp_d;
            high_q     <= high_d;
            period_q   <= period_d;
            intr_q     <= intr_d;
            ovf_q      <= ovf_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign high   = high_q;
    assign period = period_q;
    assign intr   = intr_q;
    assign ovf    = ovf_q;
    assign ovr    = ovr_q;
    assign busy   = busy_q;

endmodule

// File: rtl/pwm_capture_multi.sv
// pwm_capture_multi
// NCH independent PWM capture channels plus a registered result read mux.
//   clk, rst : clock, async active-low reset
//   bus      : pwm_capture_multi_if slave (pwm_in, trigger, stop, cont,
//              int_clr, rd_sel, oe in; intr, ovf, ovr, busy, data out)
// data = oe ? {period, high} of channel rd_sel : 0, one clk after any change;
// rd_sel values with no channel read 0. The interface must be built with the
// same NCH / CNT_W as this module.
module pwm_capture_multi
    import pwm_capture_pkg::*;
#(
    parameter int NCH         = DEF_NCH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic          clk,
    input  logic          rst,
    pwm_capture_multi_if.slave bus
);

    localparam int SEL_W = sel_width(NCH);

    logic [NCH-1:0][CNT_W-1:0] high_w, period_w;
    logic [NCH-1:0]            intr_w, ovf_w, ovr_w, busy_w;
    logic [2*CNT_W-1:0]        data_q, data_d;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        pwm_capture_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .pwm_in  (bus.pwm_in[g]),
            .trigger (bus.trigger[g]),
            .stop    (bus.stop[g]),
            .cont    (bus.cont),
            .int_clr (bus.int_clr[g]),
            .high    (high_w[g]),
            .period  (period_w[g]),
            .intr    (intr_w[g]),
            .ovf     (ovf_w[g]),
            .ovr     (ovr_w[g]),
            .busy    (busy_w[g])
        );
    end

    always_comb begin
        data_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.oe && bus.rd_sel == SEL_W'(i)) data_d = {period_w[i], high_w[i]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) data_q <= '0;
        else      data_q <= data_d;
    end

    assign bus.intr = intr_w;
    assign bus.ovf  = ovf_w;
    assign bus.ovr  = ovr_w;
    assign bus.busy = busy_w;
    assign bus.data = data_q;

endmodule

// File: doc/pwm_capture_multi.md
Name: pwm_capture_multi

Overview:
- Multi-channel, parametrised successor to the single-channel PWM capture block.
- Each channel measures high time and period of an asynchronous PWM input, in clk cycles.
- Capture modes: single-shot or continuous.
- Outputs per-channel interrupt and overflow/overrun flags, plus a muxed, output-enabled result bus for a host or LED/SPI readout top.

Parameters:
- NCH, 4, number of independent capture channels (1..16).
- CNT_W, 16, width of each high-time/period counter and result.
- SYNC_STAGES, 2, synchroniser flops on each pwm_in bit (>=2).
- SEL_W, $clog2(NCH) (min 1), width of rd_sel; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- pwm_in  in  NCH  external PWM signals, asynchronous to clk.
- trigger  in  NCH  per-channel capture start, level sampled each clk.
- stop  in  NCH  per-channel abort, returns channel to IDLE.
- cont  in  1  mode for a channel at the moment it is armed: 1 = continuous, 0 = single.
- int_clr  in  NCH  per-channel clear of int, ovf and ovr.
- rd_sel  in  SEL_W  channel selected onto data.
- oe  in  1  output enable for data.
- int  out  NCH  capture-complete flag, sticky.
- ovf  out  NCH  counter saturated before an edge, sticky.
- ovr  out  NCH  completion while int already set (continuous mode), sticky.
- busy  out  NCH  channel not in IDLE.
- data  out  2*CNT_W  {period, high} of channel rd_sel; zero when oe=0.

Behaviour:
- Reset (rst=0, async): all FSMs go to IDLE. Counters, results, int, ovf, ovr, busy, data and sync flops are all 0.
- Input path:
  - pwm_in passes through SYNC_STAGES flops to give s; d is s delayed by 1.
  - rise = s & ~d; fall = ~s & d.
  - A pin edge is seen as rise/fall SYNC_STAGES+1 clk later.
- Counter rule:
  - On rise: cnt <= 1. Otherwise cnt <= cnt+1 while in MEAS_HIGH/MEAS_LOW.
  - On fall in MEAS_HIGH: high_tmp <= cnt.
  - On rise in MEAS_LOW: period <= cnt and high <= high_tmp, both updated in the same cycle (never a torn pair).
  - Example: 3 cycles high, 5 low gives high=3, period=8.
- FSM per channel:
  - IDLE --trigger--> WAIT_RISE. cont is latched into mode_q at this point.
  - WAIT_RISE --rise--> MEAS_HIGH. A signal that is already high at arm is not measured until its next rise.
  - MEAS_HIGH --fall--> MEAS_LOW.
  - MEAS_LOW --rise--> DONE action: latch results and set int.
    - mode_q=0: go to IDLE.
    - mode_q=1: go to MEAS_HIGH with cnt=1, so back-to-back periods lose no cycle.
  - Saturation: if cnt == all-ones in MEAS_HIGH/MEAS_LOW, set ovf and int, go to IDLE, leave results unchanged. There is no wrap-around.
  - WAIT_RISE has no timeout and can wait forever; stop is the only exit.
- trigger while busy: ignored. stop in any state: IDLE next cycle, results held, no flag set.
- stop and trigger in the same cycle: stop wins.
- Flags:
  - int/ovf/ovr are set by events and cleared by int_clr.
  - A set event and int_clr in the same cycle: set wins.
  - ovr is set when a completion occurs while int is already 1. The results are still overwritten.
- Read path: data is registered, 1 clk latency from rd_sel/oe/result change.
  - data = oe ? {period[rd_sel], high[rd_sel]} : 0.
  - rd_sel >= NCH reads 0.
- Channels are fully independent. Simultaneous events on different channels need no arbitration.

Decomposition:
- Package pwm_capture_pkg holds:
  - state encoding (IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW) as localparams;
  - default NCH/CNT_W/SYNC_STAGES constants.
- Sub-module pwm_capture_chan: one channel (sync, edge detect, FSM, counter, result regs, flags). The top instantiates it NCH times via generate and adds the registered read mux.

Test Plan:
- Reset release, CNT_W=16, ch0 pwm 3 high / 5 low, trigger ch0 with cont=0 → after 1st full period: int[0]=1, busy[0]=0, data with rd_sel=0, oe=1 = {16'd8, 16'd3}; oe=0 → data=0.
- cont=1 on ch1 with pwm 10 high / 30 low → int set after each period with {40,10}. Without int_clr the 2nd completion sets ovr[1]. int_clr[1] clears all flags, unless an event lands that same cycle, in which case int stays 1.
- CNT_W=8, pwm held high 300 cycles after rise → ovf=1, int=1, FSM in IDLE, previous results unchanged.
- All 4 channels triggered together with different duty cycles (2/4, 7/7, 1/9, 50/50) → each rd_sel returns its own pair. A trigger re-pulsed mid-capture is ignored.
- stop asserted in MEAS_LOW → busy=0 next cycle, no int. stop+trigger in the same cycle → stays IDLE.
- Assert rst mid-capture in continuous mode → all outputs 0 immediately (async). After release, the channel needs a new trigger.
